// File: rtl/ram_dxw_rrw_be_clr.sv
// Single-clock RAM with a byte-enabled read/write port A and a read-only port B,
// self-clearing to CLR_VALUE after reset, with optional output register stage.
module ram_dxw_rrw_be_clr #(
    parameter int               DEPTH     = 4096,
    parameter int               WIDTH     = 32,
    parameter int               OUT_REG   = 0,
    parameter int               RDW_NEW   = 0,
    parameter logic [WIDTH-1:0] CLR_VALUE = {WIDTH{1'b0}},
    localparam int              AW        = $clog2(DEPTH),
    localparam int              BW        = WIDTH / 8
) (
    input  logic             clock,
    input  logic             reset,
    output logic             init_busy,
    input  logic [AW-1:0]    address_a,
    input  logic             wren_a,
    input  logic [BW-1:0]    be_a,
    input  logic [WIDTH-1:0] data_a,
    output logic [WIDTH-1:0] q_a,
    input  logic [AW-1:0]    address_b,
    output logic [WIDTH-1:0] q_b
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // One extra bit so DEPTH == 2**AW is still representable.
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_L  = AW'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             a_in_s, b_in_s, usr_we_s, clr_we_s;
    logic [WIDTH-1:0] rd_a_s, rd_b_s;
    logic [WIDTH-1:0] q1a_q, q1b_q;

    // Clear sequencer next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == LAST_L) begin
                    state_d = ST_READY;
                    cnt_d   = {AW{1'b0}};
                end else begin
                    state_d = ST_CLEAR;
                    cnt_d   = cnt_q + AW'(1);
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = {AW{1'b0}};
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    // Clear sequencer state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= {AW{1'b0}};
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign init_busy = busy_q;

    // Address range decode, write qualification and read-side muxing.
    always_comb begin
        a_in_s   = ({1'b0, address_a} < DEPTH_L);
        b_in_s   = ({1'b0, address_b} < DEPTH_L);
        clr_we_s = (state_q == ST_CLEAR) && !reset;
        usr_we_s = (state_q == ST_READY) && !reset && wren_a && a_in_s;
        if (a_in_s) begin
            rd_a_s = mem[address_a];
        end else begin
            rd_a_s = {WIDTH{1'b0}};
        end
        if (b_in_s) begin
            rd_b_s = mem[address_b];
        end else begin
            rd_b_s = {WIDTH{1'b0}};
        end
        // Port B bypass of same-address port A write when new data is requested.
        for (int i = 0; i < BW; i++) begin
            if ((RDW_NEW != 0) && usr_we_s && (address_a == address_b) && be_a[i]) begin
                rd_b_s[8*i +: 8] = data_a[8*i +: 8];
            end else begin
                rd_b_s[8*i +: 8] = rd_b_s[8*i +: 8];
            end
        end
    end

    // Storage array: clear writes take priority, user writes are byte-masked.
    always_ff @(posedge clock) begin
        if (clr_we_s) begin
            mem[cnt_q] <= CLR_VALUE;
        end else if (usr_we_s) begin
            for (int i = 0; i < BW; i++) begin
                if (be_a[i]) begin
                    mem[address_a][8*i +: 8] <= data_a[8*i +: 8];
                end
            end
        end
    end

    // First read stage, held at zero while clearing.
    always_ff @(posedge clock) begin
        if (reset || (state_q == ST_CLEAR)) begin
            q1a_q <= {WIDTH{1'b0}};
            q1b_q <= {WIDTH{1'b0}};
        end else begin
            q1a_q <= rd_a_s;
            q1b_q <= rd_b_s;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [WIDTH-1:0] q2a_q, q2b_q;

        // Optional output register stage, also held at zero while clearing.
        always_ff @(posedge clock) begin
            if (reset || (state_q == ST_CLEAR)) begin
                q2a_q <= {WIDTH{1'b0}};
                q2b_q <= {WIDTH{1'b0}};
            end else begin
                q2a_q <= q1a_q;
                q2b_q <= q1b_q;
            end
        end

        assign q_a = q2a_q;
        assign q_b = q2b_q;
    end else begin : g_noreg
        assign q_a = q1a_q;
        assign q_b = q1b_q;
    end

endmodule

// File: tb/tb_ram_dxw_rrw_be_clr.sv
// Drives two configurations of the RAM with identical stimulus and compares
// both against an array-based reference model of the memory behaviour.
module tb_ram_dxw_rrw_be_clr;

    localparam int          P_DEPTH [2] = '{16, 12};
    localparam int          P_OUT   [2] = '{0, 1};
    localparam int          P_RDW   [2] = '{0, 1};
    localparam logic [31:0] P_CLR   [2] = '{32'h0000_0000, 32'hA5A5_5A5A};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  addr_a = 4'h0;
    logic        wren_a = 1'b0;
    logic [3:0]  be_a = 4'h0;
    logic [31:0] data_a = 32'h0;
    logic [3:0]  addr_b = 4'h0;

    logic [31:0] act_qa [2];
    logic [31:0] act_qb [2];
    logic        act_busy [2];

    logic [31:0] m_mem [2][16];
    int          m_rem [2];
    logic [31:0] m_pa [2];
    logic [31:0] m_pb [2];
    logic [31:0] exp_qa [2];
    logic [31:0] exp_qb [2];
    logic        exp_busy [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_dxw_rrw_be_clr #(
        .DEPTH(16), .WIDTH(32), .OUT_REG(0), .RDW_NEW(0), .CLR_VALUE(32'h0000_0000)
    ) u0 (
        .clock(clk), .reset(reset), .init_busy(act_busy[0]),
        .address_a(addr_a), .wren_a(wren_a), .be_a(be_a), .data_a(data_a),
        .q_a(act_qa[0]), .address_b(addr_b), .q_b(act_qb[0])
    );

    ram_dxw_rrw_be_clr #(
        .DEPTH(12), .WIDTH(32), .OUT_REG(1), .RDW_NEW(1), .CLR_VALUE(32'hA5A5_5A5A)
    ) u1 (
        .clock(clk), .reset(reset), .init_busy(act_busy[1]),
        .address_a(addr_a), .wren_a(wren_a), .be_a(be_a), .data_a(data_a),
        .q_a(act_qa[1]), .address_b(addr_b), .q_b(act_qb[1])
    );

    // Advance the reference model by one edge, then wait for that edge.
    task automatic step();
        logic [31:0] va, vb;
        int          d;
        bit          busy_b;
        for (int k = 0; k < 2; k++) begin
            d      = P_DEPTH[k];
            busy_b = (m_rem[k] > 0);
            if (reset || busy_b) begin
                va = 32'h0;
                vb = 32'h0;
            end else begin
                va = (int'(addr_a) < d) ? m_mem[k][addr_a] : 32'h0;
                vb = (int'(addr_b) < d) ? m_mem[k][addr_b] : 32'h0;
                if (P_RDW[k] != 0 && wren_a && int'(addr_a) < d && addr_a == addr_b) begin
                    for (int i = 0; i < 4; i++)
                        if (be_a[i]) vb[8*i +: 8] = data_a[8*i +: 8];
                end
            end
            if (P_OUT[k] == 0) begin
                exp_qa[k] = va;
                exp_qb[k] = vb;
            end else begin
                exp_qa[k] = (reset || busy_b) ? 32'h0 : m_pa[k];
                exp_qb[k] = (reset || busy_b) ? 32'h0 : m_pb[k];
                m_pa[k]   = va;
                m_pb[k]   = vb;
            end
            if (reset) begin
                m_rem[k] = d;
            end else if (busy_b) begin
                m_mem[k][d - m_rem[k]] = P_CLR[k];
                m_rem[k]--;
            end else if (wren_a && int'(addr_a) < d) begin
                for (int i = 0; i < 4; i++)
                    if (be_a[i]) m_mem[k][addr_a][8*i +: 8] = data_a[8*i +: 8];
            end
            exp_busy[k] = (m_rem[k] > 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_busy[k] !== 1'b1 || act_qa[k] !== 32'h0 || act_qb[k] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset inst%0d: busy=%b qa=%h qb=%h, required busy=1 qa=0 qb=0",
                             k, act_busy[k], act_qa[k], act_qb[k]);
                end
            end
        end
    endtask

    // Count busy edges from the current point while random writes are attempted.
    task automatic run_clear(input string name);
        int cnt [2];
        cnt = '{0, 0};
        for (int c = 0; c < 40 && (act_busy[0] || act_busy[1]); c++) begin
            for (int k = 0; k < 2; k++) if (act_busy[k] === 1'b1) cnt[k]++;
            wren_a = 1'b1;
            be_a   = 4'hF;
            addr_a = 4'($urandom_range(0, 15));
            addr_b = 4'($urandom_range(0, 15));
            data_a = $urandom;
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_busy[k] !== exp_busy[k] || act_qa[k] !== exp_qa[k] || act_qb[k] !== exp_qb[k]) begin
                    errors++;
                    $display("FAIL %s_cycle inst%0d: busy=%b qa=%h qb=%h, required %b %h %h",
                             name, k, act_busy[k], act_qa[k], act_qb[k], exp_busy[k], exp_qa[k], exp_qb[k]);
                end
            end
        end
        wren_a = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (cnt[k] != P_DEPTH[k]) begin
                errors++;
                $display("FAIL %s_busy_len inst%0d: got %0d edges, required %0d", name, k, cnt[k], P_DEPTH[k]);
            end
        end
        // Read back every address on both ports.
        for (int a = 0; a < 18; a++) begin
            addr_a = 4'(a % 16);
            addr_b = 4'(15 - (a % 16));
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_qa[k] !== exp_qa[k] || act_qb[k] !== exp_qb[k]) begin
                    errors++;
                    $display("FAIL %s_readback inst%0d addr=%0d: qa=%h qb=%h, required %h %h",
                             name, k, a % 16, act_qa[k], act_qb[k], exp_qa[k], exp_qb[k]);
                end
            end
            checks++;
            if (a < 16 && (act_qa[0] !== 32'h0 || act_qb[0] !== 32'h0)) begin
                errors++;
                $display("FAIL %s_zero inst0 addr=%0d: qa=%h qb=%h, required 00000000", name, a, act_qa[0], act_qb[0]);
            end
        end
    endtask

    task automatic test_clear();
        reset = 1'b0;
        run_clear("clear");
    endtask

    task automatic test_rdw();
        wren_a = 1'b1; addr_a = 4'd3; addr_b = 4'd3; be_a = 4'hF; data_a = 32'hCAFE_F00D;
        step();
        checks++;
        if (act_qb[0] !== 32'h0000_0000 || act_qa[0] !== 32'h0000_0000) begin
            errors++;
            $display("FAIL rdw_old inst0: qa=%h qb=%h, required 00000000", act_qa[0], act_qb[0]);
        end
        wren_a = 1'b0;
        step();
        checks++;
        if (act_qb[1] !== 32'hCAFE_F00D || act_qb[0] !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL rdw_new: qb0=%h qb1=%h, required cafef00d", act_qb[0], act_qb[1]);
        end
        checks++;
        if (act_qa[1] !== 32'hA5A5_5A5A) begin
            errors++;
            $display("FAIL rdw_porta_old inst1: qa=%h, required a5a55a5a", act_qa[1]);
        end
        step();
        checks++;
        if (act_qb[1] !== 32'hCAFE_F00D || act_qa[1] !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL rdw_follow inst1: qa=%h qb=%h, required cafef00d", act_qa[1], act_qb[1]);
        end
    endtask

    task automatic test_byte_enable();
        wren_a = 1'b1; addr_a = 4'd5; be_a = 4'hF; data_a = 32'hAABB_CCDD;
        step();
        be_a = 4'h2; data_a = 32'h1122_3344;
        step();
        wren_a = 1'b1; be_a = 4'h0; data_a = 32'hFFFF_FFFF;
        step();
        wren_a = 1'b0; addr_b = 4'd5;
        step();
        checks++;
        if (act_qa[0] !== 32'hAABB_33DD || act_qb[0] !== 32'hAABB_33DD) begin
            errors++;
            $display("FAIL be_lat1 inst0: qa=%h qb=%h, required aabb33dd", act_qa[0], act_qb[0]);
        end
        step();
        checks++;
        if (act_qa[1] !== 32'hAABB_33DD || act_qb[1] !== 32'hAABB_33DD) begin
            errors++;
            $display("FAIL be_lat2 inst1: qa=%h qb=%h, required aabb33dd", act_qa[1], act_qb[1]);
        end
    endtask

    task automatic test_out_of_range();
        wren_a = 1'b1; addr_a = 4'd13; be_a = 4'hF; data_a = 32'h1234_5678;
        step();
        wren_a = 1'b0;
        step();
        step();
        checks++;
        if (act_qa[1] !== 32'h0 || act_qa[0] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL oor_addr13: qa0=%h qa1=%h, required 12345678 00000000", act_qa[0], act_qa[1]);
        end
        for (int a = 0; a < 17; a++) begin
            addr_a = 4'(a % 16);
            addr_b = 4'(a % 16);
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_qa[k] !== exp_qa[k] || act_qb[k] !== exp_qb[k]) begin
                    errors++;
                    $display("FAIL oor_scan inst%0d addr=%0d: qa=%h qb=%h, required %h %h",
                             k, a % 16, act_qa[k], act_qb[k], exp_qa[k], exp_qb[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            wren_a = 1'($urandom_range(0, 1));
            be_a   = 4'($urandom);
            data_a = $urandom;
            addr_a = 4'($urandom);
            addr_b = ($urandom_range(0, 3) == 0) ? addr_a : 4'($urandom);
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_busy[k] !== exp_busy[k] || act_qa[k] !== exp_qa[k] || act_qb[k] !== exp_qb[k]) begin
                    errors++;
                    $display("FAIL random inst%0d cyc=%0d: busy=%b qa=%h qb=%h, required %b %h %h",
                             k, c, act_busy[k], act_qa[k], act_qb[k], exp_busy[k], exp_qa[k], exp_qb[k]);
                end
            end
        end
        wren_a = 1'b0;
    endtask

    task automatic test_reset_mid_clear();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        run_clear("midclr");
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_rem[k] = P_DEPTH[k];
            m_pa[k]  = 32'h0;
            m_pb[k]  = 32'h0;
            for (int a = 0; a < 16; a++) m_mem[k][a] = 32'h0;
        end
        test_reset();
        test_clear();
        test_rdw();
        test_byte_enable();
        test_out_of_range();
        test_random();
        test_reset_mid_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
